mv_pack_fifo: RTL and testbench

Parametrised successor to the fixed 8-lane move FIFO inside the legal-move generator. It accepts individual moves one per cycle over a valid/ready handshake and packs LANES moves into one output word. Packed words are buffered in a DEPTH-entry FIFO. On flush, a partial word is padded with invalid-marked slots, and done is raised once everything is buffered. It sits between the move generator core and the search/readout logic, with the same fifoOut/rden/fifoEmpty read interface and move format as the existing generator.

---
 rtl/mv_pack_fifo.sv | 118 +++++++++++
 tb/tb_mv_pack_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mv_pack_fifo.sv
// mv_pack_fifo: packs LANES moves per word into a DEPTH-entry FIFO, pads partial words on flush.
module mv_pack_fifo #(
    parameter int MV_W  = 19,
    parameter int LANES = 8,
    parameter int DEPTH = 16,
    parameter int OUT_W = 160,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             mv_valid,
    input  logic [MV_W-1:0]  mv_in,
    output logic             mv_ready,
    input  logic             flush,
    output logic             done,
    input  logic             rden,
    output logic [OUT_W-1:0] fifoOut,
    output logic             fifoEmpty,
    output logic [CNT_W-1:0] mv_count,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WW = LANES * MV_W;
    localparam logic [1:0] S_ACCEPT = 2'd0;
    localparam logic [1:0] S_PAD    = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [MV_W-1:0] PAD_MV = {1'b1, {(MV_W-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [MV_W-1:0]  lanes_q [LANES];
    logic [MV_W-1:0]  lanes_d [LANES];
    logic [WW-1:0]    word_q, word_d, nxt_word;
    logic             pend_q, pend_d;
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [OUT_W-1:0] mem_q [DEPTH];
    logic             full, empty, push, pop, accept, last, load, inc, sat;

    assign empty     = wr_q == rd_q;
    assign full      = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign push      = pend_q && !full;
    assign pop       = rden && !empty;
    assign mv_ready  = (state_q == S_ACCEPT) && !(pend_q && full);
    assign accept    = mv_valid && mv_ready;
    assign last      = accept && (lane_q == LW'(LANES - 1));
    assign load      = (state_q == S_PAD) && !pend_q && (lane_q != '0);
    assign inc       = accept && !mv_in[MV_W-1];
    assign sat       = cnt_q == '1;
    assign done      = state_q == S_DONE;
    assign fifoOut   = out_q;
    assign fifoEmpty = empty;
    assign mv_count  = cnt_q;
    assign overflow  = ovf_q;

    always_comb begin
        lanes_d = lanes_q;
        if (accept) lanes_d[lane_q] = mv_in;
        nxt_word = '0;
        for (int i = 0; i < LANES; i++) nxt_word[WW-1-i*MV_W -: MV_W] = lanes_d[i];
        lane_d  = (last || load) ? '0 : lane_q + LW'(accept);
        word_d  = (last || load) ? nxt_word : word_q;
        pend_d  = last || load || (pend_q && !push);
        cnt_d   = cnt_q + CNT_W'(inc && !sat);
        ovf_d   = ovf_q || (inc && sat);
        wr_d    = wr_q + (AW+1)'(push);
        rd_d    = rd_q + (AW+1)'(pop);
        out_d   = pop ? mem_q[rd_q[AW-1:0]] : out_q;
        state_d = (state_q == S_ACCEPT && flush) ? S_PAD :
                  (state_q == S_PAD && !pend_q && lane_q == '0) ? S_DONE : state_q;
        // a completed or padded word leaves the lane buffer pre-filled with pad slots
        if (last || load || clear) for (int i = 0; i < LANES; i++) lanes_d[i] = PAD_MV;
        if (clear) begin
            state_d = S_ACCEPT;
            lane_d  = '0;
            pend_d  = 1'b0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            out_d   = out_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ACCEPT;
            lane_q  <= '0;
            for (int i = 0; i < LANES; i++) lanes_q[i] <= PAD_MV;
            word_q  <= '0;
            pend_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            lanes_q <= lanes_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= OUT_W'(word_q);
    end
endmodule

// File: tb/tb_mv_pack_fifo.sv
// tb_mv_pack_fifo: random and directed stimulus against a move-list reference model.
module tb_mv_pack_fifo;
    localparam int MV_W  = 19;
    localparam int LANES = 8;
    localparam int DEPTH = 16;
    localparam int OUT_W = 160;
    localparam int CNT_W = 8;
    localparam logic [MV_W-1:0] PAD_MV = 19'h40000;

    logic             clk = 1'b0;
    logic             reset, clear, mv_valid, mv_ready, flush, done, rden, fifoEmpty, overflow;
    logic [MV_W-1:0]  mv_in;
    logic [OUT_W-1:0] fifoOut;
    logic [CNT_W-1:0] mv_count;

    mv_pack_fifo #(.MV_W(MV_W), .LANES(LANES), .DEPTH(DEPTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .mv_valid(mv_valid), .mv_in(mv_in),
        .mv_ready(mv_ready), .flush(flush), .done(done), .rden(rden), .fifoOut(fifoOut),
        .fifoEmpty(fifoEmpty), .mv_count(mv_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [MV_W-1:0]  moves [$];
    logic [OUT_W-1:0] expq [$];
    int  nvalid = 0;
    bit  mflushed = 0;
    bit  last_acc;
    logic [OUT_W-1:0] held;

    task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // lane 0 = first move, landing in the most significant slot; missing lanes are pads
    task automatic emit();
        logic [OUT_W-1:0] w = '0;
        for (int i = 0; i < LANES; i++) w = (w << MV_W) | OUT_W'(i < moves.size() ? moves[i] : PAD_MV);
        expq.push_back(w);
        moves.delete();
    endtask

    task automatic model_clear();
        moves.delete();
        expq.delete();
        nvalid = 0;
        mflushed = 0;
    endtask

    task automatic cycle(input logic v, input logic [MV_W-1:0] m, input logic fl, input logic rd, input logic clr);
        logic pop;
        mv_valid = v; mv_in = m; flush = fl; rden = rd; clear = clr;
        last_acc = v && mv_ready && !clr;
        pop = rd && !fifoEmpty && !clr;
        @(posedge clk);
        if (clr) model_clear();
        else begin
            if (last_acc) begin
                moves.push_back(m);
                if (!m[MV_W-1]) nvalid++;
                if (moves.size() == LANES) emit();
            end
            if (fl && !mflushed) begin
                mflushed = 1;
                if (moves.size() != 0) emit();
            end
        end
        #1;
        if (pop) begin
            check("word_avail", OUT_W'(expq.size() != 0), 1);
            if (expq.size() != 0) check("fifo_word", fifoOut, expq.pop_front());
        end
        @(negedge clk);
        mv_valid = 0; flush = 0; rden = 0; clear = 0;
    endtask

    task automatic send(input logic [MV_W-1:0] m, input logic fl);
        int k = 0;
        do begin cycle(1, m, fl, 0, 0); k++; end while (!last_acc && k < 50);
        check("send_accepted", OUT_W'(last_acc), 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 60) begin cycle(0, '0, 0, 0, 0); k++; end
        check("done", OUT_W'(done), 1);
    endtask

    task automatic drain();
        int k = 0;
        while (!fifoEmpty && k < 200) begin cycle(0, '0, 0, 1, 0); k++; end
        check("drain_empty", OUT_W'(fifoEmpty), 1);
        check("model_empty", OUT_W'(expq.size()), 0);
    endtask

    task automatic check_count();
        check("mv_count", OUT_W'(mv_count), OUT_W'(nvalid > 255 ? 255 : nvalid));
        check("overflow", OUT_W'(overflow), OUT_W'(nvalid > 255));
    endtask

    function automatic logic [MV_W-1:0] sq_move(input int i);
        logic [MV_W-1:0] m = '0;
        m[11:6] = 6'(10 + i);
        m[5:0]  = 6'(28 + i);
        return m;
    endfunction

    function automatic logic [MV_W-1:0] rnd_move();
        logic [MV_W-1:0] m = MV_W'($urandom);
        m[MV_W-1] = ($urandom_range(0, 7) == 0);
        return m;
    endfunction

    initial begin
        reset = 0; clear = 0; mv_valid = 0; mv_in = '0; flush = 0; rden = 0;
        repeat (2) @(negedge clk);
        check("rst_fifoOut", fifoOut, 0);
        check("rst_empty", OUT_W'(fifoEmpty), 1);
        check("rst_done", OUT_W'(done), 0);
        check("rst_count", OUT_W'(mv_count), 0);
        check("rst_ovf", OUT_W'(overflow), 0);
        reset = 1;
        @(negedge clk);
        check("rst_ready", OUT_W'(mv_ready), 1);

        for (int i = 0; i < 8; i++) send(sq_move(i), 0);
        cycle(0, '0, 1, 0, 0);
        wait_done();
        check_count();
        drain();
        cycle(0, '0, 1, 0, 0);
        check("flush_in_done", OUT_W'(fifoEmpty), 1);

        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 11; i++) send(sq_move(i), 0);
        cycle(0, '0, 1, 0, 0);
        wait_done();
        check_count();
        drain();

        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 8; i++) send(rnd_move(), 0);
        send(sq_move(3), 1);
        wait_done();
        drain();

        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 1, 0, 0);
        wait_done();
        check("zero_empty", OUT_W'(fifoEmpty), 1);
        check("zero_count", OUT_W'(mv_count), 0);

        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 17 * LANES; i++) send(rnd_move(), 0);
        check("full_stall", OUT_W'(mv_ready), 0);
        cycle(0, '0, 0, 1, 0);
        check("ready_back", OUT_W'(mv_ready), 1);
        cycle(0, '0, 1, 0, 0);
        wait_done();
        check_count();
        drain();

        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 300; i++) cycle($urandom_range(0, 3) != 0, rnd_move(), 0, $urandom_range(0, 1), 0);
        cycle(0, '0, 1, 0, 0);
        wait_done();
        check_count();
        drain();

        begin
            int stalls = 0;
            cycle(0, '0, 0, 0, 1);
            for (int i = 0; i < 42 * LANES + 3; i++) begin
                if (!mv_ready) stalls++;
                cycle(1, rnd_move(), 0, 1, 0);
            end
            check("no_stall", OUT_W'(stalls), 0);
            cycle(0, '0, 1, 0, 0);
            wait_done();
            check_count();
            drain();
        end

        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) send(rnd_move(), 0);
        reset = 0;
        #1;
        check("arst_fifoOut", fifoOut, 0);
        check("arst_empty", OUT_W'(fifoEmpty), 1);
        check("arst_count", OUT_W'(mv_count), 0);
        check("arst_done", OUT_W'(done), 0);
        model_clear();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send(sq_move(i), 0);
        repeat (2) cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 0, 1, 0);
        held = fifoOut;
        for (int i = 0; i < 3; i++) send(rnd_move(), 0);
        cycle(1, rnd_move(), 0, 0, 1);
        check("clr_empty", OUT_W'(fifoEmpty), 1);
        check("clr_count", OUT_W'(mv_count), 0);
        check("clr_done", OUT_W'(done), 0);
        check("clr_fifoOut_hold", fifoOut, held);
        for (int i = 0; i < 3; i++) send(sq_move(i), 0);
        cycle(0, '0, 1, 0, 0);
        wait_done();
        check_count();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
